rr_mux4_arbiter: RTL
====================

Name: rr_mux4_arbiter

Overview:
Round-robin arbiter that shares one 4:1 data mux between four requesters, each with a valid/ready handshake. It selects one requester per cycle and drives the mux select from the grant. The selected word is registered into a single-entry output stage with its own valid/ready handshake. It sits in front of any shared downstream consumer, such as a bus, FIFO or serializer, that takes one of four sources at a time.

Parameters:
DATA_W, 8, width of each requester's data word and of out_data
CNT_W, 16, width of each per-requester grant counter; used only when ARB_STATS_EN is defined

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  4  bit i = requester i has a word to send
in_data  input  4*DATA_W  requester i word at [i*DATA_W +: DATA_W]
in_ready  output  4  one-hot or zero; bit i = requester i's word is taken this cycle
out_valid  output  1  output register holds a word
out_data  output  DATA_W  registered word
out_sel  output  2  index of the requester that supplied out_data
out_ready  input  1  downstream accepts out_data this cycle
grant_cnt  output  4*CNT_W  present only with ARB_STATS_EN; per-requester grant counts

Behaviour:
- Reset state (rst=1 at a clock edge): out_valid=0, out_data=0, out_sel=0, last_grant=3 (so requester 0 wins first), grant_cnt all 0. in_ready=0 whenever rst=1. rst has priority over every other event.
- free = !out_valid || out_ready (combinational).
- Grant selection (combinational):
  - Search order is last_grant+1, +2, +3, +4, all modulo 4.
  - The first index with in_valid set is g.
  - With no valid requester there is no grant.
- in_ready[g] = 1 only when free=1 and a grant exists. All other bits are 0. in_ready is never more than one-hot.
- Transfer edge (free && grant):
  - out_data <= in_data lane g; out_sel <= g; out_valid <= 1; last_grant <= g.
- Drain-only edge (out_valid && out_ready, no grant): out_valid <= 0. out_data and out_sel hold their values.
- Stall (out_valid && !out_ready):
  - in_ready=0. out_valid, out_data, out_sel and last_grant hold.
  - Requester inputs may change; arbitration is re-evaluated when the stage frees.
- Latency: word accepted at edge N is visible on out_data after edge N.
- Throughput: one word per cycle when out_ready is held at 1.
- Fairness: with all four requesters continuously valid, grant order is 0,1,2,3,0,... A requester waits at most 3 transfers.
- Requesters that are not valid are skipped with no idle cycle inserted.
- last_grant updates only on a transfer; stalls and idle cycles do not rotate priority.
- Simultaneous drain and load in the same cycle is a valid transfer; out_valid stays 1.
- Reset during a stall discards the held word; out_valid=0 on the next cycle.
- Requesters must hold in_valid and in_data until they see in_ready. The arbiter does not check this.
- The mux select is driven only by the grant index (2 bits). There is no default path that outputs a wrong lane.

Optional Feature:
Macro: ARB_STATS_EN
- Defined:
  - Adds output grant_cnt with four saturating CNT_W-bit counters. Lane i is at [i*CNT_W +: CNT_W].
  - Counter i increments on each transfer edge where g=i and holds at all ones.
  - Counters clear on rst.
- Undefined: the grant_cnt port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset hold: rst=1 for 3 cycles with in_valid=4'hF → out_valid=0, in_ready=0, out_sel=0; the first grant after release goes to requester 0.
- Full-load rotation: in_valid=4'hF, lane data 8'hA0..8'hA3, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0, no bubbles.
- Skip idle requesters: in_valid=4'b1010, out_ready=1 → grants alternate 1,3,1,3; in_ready[0] and in_ready[2] are never 1.
- Backpressure: hold out_ready=0 for 4 cycles after word from requester 2 (8'h5C) → out_data=8'h5C, out_valid=1, in_ready=0 throughout. Then raise out_ready → the next grant is requester 3 if valid.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle → out_valid=0 next cycle, last_grant=3, the next grant is requester 0.
- ARB_STATS_EN build with CNT_W=4, only requester 1 valid for 20 transfers → grant_cnt lane 1 saturates at 4'hF, other lanes stay 0.

Source files
------------

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: four-way round-robin arbiter feeding a shared 4:1 data mux.
// The granted requester's word is captured into a single-entry output register
// with its own valid/ready handshake. Priority rotates only on a transfer, so
// stalls and idle cycles never change the order in which requesters are served.
//
// Optional feature: define ARB_STATS_EN to add the grant_cnt output. It holds
// four saturating CNT_W-bit per-requester grant counters.
module rr_mux4_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_sel,
    input  logic                out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [4*CNT_W-1:0]  grant_cnt
`endif
);

    // Round-robin search starting one past the last winner.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!pick[2] && req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [1:0]        out_sel_r;
    logic [1:0]        last_grant_r;

    logic [2:0]        pick_s;
    logic              grant_valid_s;
    logic [1:0]        grant_idx_s;
    logic              free_s;
    logic              transfer_s;
    logic [DATA_W-1:0] mux_data_s;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

    // The mux select comes only from the 2-bit grant index. Every value names a real lane.
    assign mux_data_s = in_data[grant_idx_s*DATA_W +: DATA_W];

    // Arbitration, stage-free detection and one-hot ready generation.
    always_comb begin
        pick_s        = rr_pick(last_grant_r, in_valid);
        grant_valid_s = pick_s[2];
        grant_idx_s   = pick_s[1:0];
        free_s        = !out_valid_r || out_ready;
        transfer_s    = !rst && free_s && grant_valid_s;
        in_ready      = 4'b0000;
        if (transfer_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Output stage and priority pointer.
    // Load on transfer, clear on drain-only, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            out_sel_r    <= 2'd0;
            last_grant_r <= 2'd3;
        end else if (transfer_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= mux_data_s;
            out_sel_r    <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_r [4];

    // Per-requester grant counters. Each counter saturates at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else if (transfer_s && (cnt_r[grant_idx_s] != {CNT_W{1'b1}})) begin
            cnt_r[grant_idx_s] <= cnt_r[grant_idx_s] + CNT_W'(1);
        end else begin
            cnt_r[grant_idx_s] <= cnt_r[grant_idx_s];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_out
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_r[gi];
    end
`endif

endmodule
